// File: rtl/bch_syndrome_framer_pkg.sv
// rtl/bch_syndrome_framer_pkg.sv - shared FSM encoding and sizing helper for the BCH syndrome framer
package bch_syndrome_framer_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_CAPTURE = 2'd2
  } framer_state_t;

  localparam int MAX_PIPELINE_STAGES = 2;

  // Ceiling log2, never below 1 for any value >= 2.
  function automatic int bch_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((value - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_syndrome_framer.sv
// rtl/bch_syndrome_framer.sv - frames codeword beats into common syndrome units and captures their results
module bch_syndrome_framer
  import bch_syndrome_framer_pkg::*;
#(
  parameter int M               = 8,
  parameter int NSYN            = 4,
  parameter int BITS            = 1,
  parameter int BEATS           = 255,
  parameter int PIPELINE_STAGES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BITS-1:0]     in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                syn_start,
  output logic                syn_start_pipelined,
  output logic                syn_ce,
  output logic [BITS-1:0]     syn_data,
  input  logic [NSYN*M-1:0]   syn_in,
  output logic [NSYN*M-1:0]   out_syn,
  output logic                out_nonzero,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int                CNT_W      = bch_clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'((PIPELINE_STAGES > 0) ? PIPELINE_STAGES - 1 : 0);

  framer_state_t       r_state;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [1:0]          r_drain_cnt;
  logic                r_out_valid;
  logic [NSYN*M-1:0]   r_out_syn;
  logic                r_out_nonzero;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_start;
  logic                w_last;
  logic                w_drain;
  logic                w_ce;
  logic                w_capture;
  logic [BITS-1:0]     w_gated_data;

  // Every strobe is gated by rst_n so nothing leaks out while reset is held.
  assign w_in_ready   = rst_n && (r_state == ST_RUN);
  assign w_accept     = in_valid && w_in_ready;
  assign w_start      = w_accept && (r_beat_cnt == '0);
  assign w_last       = w_accept && (r_beat_cnt == LAST_BEAT);
  assign w_drain      = rst_n && (r_state == ST_DRAIN);
  assign w_ce         = w_accept || w_drain;
  assign w_gated_data = w_accept ? in_data : '0;
  assign w_capture    = rst_n && (r_state == ST_CAPTURE) && (!r_out_valid || out_ready);

  assign in_ready    = w_in_ready;
  assign syn_start   = w_start;
  assign syn_ce      = w_ce;
  assign out_syn     = r_out_syn;
  assign out_nonzero = r_out_nonzero;
  assign out_valid   = r_out_valid;

  generate
    if (PIPELINE_STAGES == MAX_PIPELINE_STAGES) begin : g_stage
      logic [BITS-1:0] r_stg_data;
      logic            r_stg_start;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_stg_data  <= '0;
          r_stg_start <= 1'b0;
        end else if (w_ce) begin
          r_stg_data  <= w_gated_data;
          r_stg_start <= w_start;
        end
      end

      assign syn_data            = r_stg_data;
      assign syn_start_pipelined = r_stg_start && rst_n;
    end else begin : g_direct
      assign syn_data            = w_gated_data;
      assign syn_start_pipelined = w_start;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_beat_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_out_valid   <= 1'b0;
      r_out_syn     <= '0;
      r_out_nonzero <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            if (w_last) begin
              r_beat_cnt  <= '0;
              r_drain_cnt <= '0;
              r_state     <= (PIPELINE_STAGES > 0) ? ST_DRAIN : ST_CAPTURE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Zeros are clocked in until the last real beat reaches the accumulators.
          r_drain_cnt <= r_drain_cnt + 2'd1;
          if (r_drain_cnt == DRAIN_LAST) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (w_capture) begin
            r_out_syn     <= syn_in;
            r_out_nonzero <= |syn_in;
            r_out_valid   <= 1'b1;
            r_state       <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/bch_syndrome_framer.md
BCH_SYNDROME_FRAMER -- requirements
Module: bch_syndrome_framer

Interface
REQ-001 SHALL have parameter M, default 8: GF(2^M) syndrome width in bits.
REQ-002 SHALL have parameter NSYN, default 4: number of syndrome units served.
REQ-003 SHALL have parameter BITS, default 1: codeword bits per beat.
REQ-004 SHALL have parameter BEATS, default 255: beats per codeword, BEATS >= 2; upstream pads the codeword to BEATS*BITS bits.
REQ-005 SHALL have parameter PIPELINE_STAGES, default 0: syndrome-unit pipeline depth, legal values 0..2.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port in_data, input, BITS bits: codeword beat, MSB-first within the codeword.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the framer accepts a beat this cycle.
REQ-011 SHALL have port syn_start, output, 1 bit: start to the syndrome units.
REQ-012 SHALL have port syn_start_pipelined, output, 1 bit: start_pipelined to the syndrome units.
REQ-013 SHALL have port syn_ce, output, 1 bit: ce to the syndrome units.
REQ-014 SHALL have port syn_data, output, BITS bits: data_pipelined to the syndrome units.
REQ-015 SHALL have port syn_in, input, NSYN*M bits: concatenated synN outputs of the syndrome units, unit 0 in the LSBs.
REQ-016 SHALL have port out_syn, output, NSYN*M bits: captured syndromes.
REQ-017 SHALL have port out_nonzero, output, 1 bit: OR-reduction of out_syn.
REQ-018 SHALL have port out_valid, output, 1 bit: out_syn and out_nonzero are valid.
REQ-019 SHALL have port out_ready, input, 1 bit: downstream consumes the output.

Function
REQ-020 SHALL implement an FSM with states RUN, DRAIN and CAPTURE.
REQ-021 SHALL, in RUN, drive in_ready=1; a beat is accepted when in_valid && in_ready.
REQ-022 SHALL count accepted beats in beat_cnt, width clog2(BEATS), from 0 to BEATS-1, and wrap it to 0 after the last beat.
REQ-023 SHALL drive syn_start=1 combinationally in the cycle the beat with beat_cnt==0 is accepted.
REQ-024 SHALL drive syn_ce=1 in every accepted-beat cycle and in every DRAIN cycle, and syn_ce=0 otherwise; an idle RUN cycle (in_valid=0) freezes the syndrome units.
REQ-025 SHALL, for PIPELINE_STAGES<2, drive syn_data as in_data gated by acceptance (0 when no beat is accepted) and syn_start_pipelined equal to syn_start.
REQ-026 SHALL, for PIPELINE_STAGES==2, drive syn_data and syn_start_pipelined from one ce-qualified register stage holding the gated in_data and syn_start.
REQ-027 SHALL, on acceptance of the last beat, go to DRAIN when PIPELINE_STAGES>0 and to CAPTURE when PIPELINE_STAGES==0.
REQ-028 SHALL stay in DRAIN for exactly PIPELINE_STAGES cycles with in_ready=0, syn_ce=1 and zero data entering the pipeline, then go to CAPTURE.
REQ-029 SHALL, in CAPTURE, drive in_ready=0 and syn_ce=0; when the output register is empty, or is being consumed this cycle (out_valid && out_ready), it latches syn_in into out_syn, sets out_valid=1 and returns to RUN.
REQ-030 SHALL otherwise remain in CAPTURE, holding the syndrome units frozen, which is the backpressure path.
REQ-031 SHALL clear out_valid on out_valid && out_ready unless a capture occurs in the same cycle, in which case out_valid stays 1 with the new data.
REQ-032 SHALL keep out_syn and out_nonzero stable while out_valid && !out_ready.
REQ-033 SHALL give the latency from last-beat acceptance to out_valid as PIPELINE_STAGES+2 cycles when the output register is free.
REQ-034 SHALL achieve a sustained throughput of BEATS beats per BEATS+PIPELINE_STAGES+1 cycles.

Reset
REQ-035 SHALL, while rst_n=0 at a clock edge, set state=RUN, beat_cnt=0, out_valid=0, out_syn=0, out_nonzero=0 and the stage-2 registers to 0.
REQ-036 SHALL, while rst_n=0, drive syn_ce, syn_start, syn_start_pipelined and in_ready to 0.
REQ-037 SHALL, on a reset applied mid-codeword or mid-CAPTURE, discard the partial codeword; the next accepted beat after reset is beat 0.

Structure
REQ-038 SHALL place the FSM state encoding and the clog2 helper in the shared BCH package or include file.
REQ-039 SHALL instantiate no sub-module; the stage-2 register uses the existing pipeline_ce primitive.
REQ-040 SHALL sit directly upstream of the dsynN_method1 instances and drive all of them in common.

Verification
REQ-041 SHALL cover: M=4, BITS=1, BEATS=15, stages 0, all-zero codeword streamed back to back -> out_valid 2 cycles after beat 14, out_syn=0, out_nonzero=0.
REQ-042 SHALL cover: the same configuration with a single 1 at beat 0 -> out_nonzero=1 and out_syn matching the golden model; start pulses exactly once per codeword.
REQ-043 SHALL cover: stages=2, BITS=4, BEATS=4 -> 2 DRAIN cycles, out_valid 4 cycles after the last beat, syn_start_pipelined 1 cycle after syn_start.
REQ-044 SHALL cover: out_ready=0 for 20 cycles with a second codeword complete -> FSM holds in CAPTURE, in_ready=0, out_syn unchanged; out_ready=1 -> second result captured in the same cycle the first is consumed.
REQ-045 SHALL cover: in_valid toggling 1/0 every cycle -> syn_ce mirrors acceptance and syndromes equal the gap-free result.
REQ-046 SHALL cover: rst_n=0 at beat 7 of 15 -> out_valid=0; the next codeword yields the correct syndromes.
